// File: rtl/rr_req_collector.sv
// Request collector ahead of the round-robin arbiter: per-source pending counters plus an
// IDLE/ISSUE/WAIT handshake. Define RR_REQ_OVF_STICKY_EN for sticky per-source overflow flags.
module rr_req_collector #(
  parameter int unsigned REQCNT   = 5,
  parameter int unsigned REQWIDTH = $clog2(REQCNT),
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNTW     = $clog2(DEPTH + 1),
  parameter int unsigned TMO      = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [REQCNT-1:0]   strobe_i,
  input  logic [REQWIDTH-1:0] grant_num_i,
  input  logic                grant_val_i,
  output logic [REQCNT-1:0]   req_o,
  output logic                req_val_o,
  output logic                busy_o,
  output logic                tmo_o,
  output logic                gerr_o,
  output logic [REQCNT-1:0]   ovf_o,
  input  logic [REQCNT-1:0]   ovf_clr_i
);

  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q;
  logic [TW-1:0]     timer_q;
  logic [CNTW-1:0]   cnt_q [REQCNT];
  logic [CNTW-1:0]   cnt_d [REQCNT];
  logic [REQCNT-1:0] pend;
  logic [REQCNT-1:0] grant_oh;
  logic [REQCNT-1:0] dec;
  logic [REQCNT-1:0] ovf_ev;
  logic              grant_legal;

  // Out-of-range grant numbers never match a one-hot bit, so they are illegal by construction.
  always_comb begin
    pend     = '0;
    grant_oh = '0;
    for (int i = 0; i < int'(REQCNT); i++) begin
      pend[i]     = (cnt_q[i] != '0);
      grant_oh[i] = (grant_num_i == REQWIDTH'(i));
    end
  end

  assign grant_legal = (state_q == StWait) && grant_val_i && (|(grant_oh & req_o & pend));
  assign dec         = {REQCNT{grant_legal}} & grant_oh;

  always_comb begin
    ovf_ev = '0;
    for (int i = 0; i < int'(REQCNT); i++) begin
      cnt_d[i] = cnt_q[i];
      if (strobe_i[i] && !dec[i]) begin
        if (cnt_q[i] == CNTW'(DEPTH)) begin
          ovf_ev[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNTW'(1);
        end
      end else if (dec[i] && !strobe_i[i]) begin
        cnt_d[i] = cnt_q[i] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(REQCNT); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(REQCNT); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      req_o     <= '0;
      req_val_o <= 1'b0;
      tmo_o     <= 1'b0;
      gerr_o    <= 1'b0;
    end else begin
      req_val_o <= 1'b0;
      tmo_o     <= 1'b0;
      gerr_o    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|pend) begin
            state_q   <= StIssue;
            req_o     <= pend;
            req_val_o <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWait;
          timer_q <= '0;
        end
        StWait: begin
          // A grant on the final timer cycle takes priority over expiry.
          if (grant_val_i) begin
            state_q <= StIdle;
            gerr_o  <= !grant_legal;
          end else if (timer_q == TW'(TMO - 1)) begin
            state_q <= StIdle;
            tmo_o   <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);

`ifdef RR_REQ_OVF_STICKY_EN
  logic [REQCNT-1:0] ovf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_ev | (ovf_q & ~ovf_clr_i);
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_ev, ovf_clr_i};
  assign ovf_o      = '0;
`endif

endmodule

// File: tb/tb_rr_req_collector.sv
// Scoreboard bench for rr_req_collector: directed stimulus pushes expected snapshots, timeouts
// and grant errors; an independent monitor pops and compares whenever the DUT raises one.
module tb_rr_req_collector;

  localparam int KREQ  = 0;
  localparam int KTMO  = 1;
  localparam int KGERR = 2;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] strobe;
  logic [2:0] gnum;
  logic       gval;
  logic [4:0] req;
  logic       req_val;
  logic       busy;
  logic       tmo;
  logic       gerr;
  logic [4:0] ovf;
  logic [4:0] ovf_clr;

  typedef struct {
    int         kind;
    logic [4:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

`ifdef RR_REQ_OVF_STICKY_EN
  localparam logic [4:0] ExpOvf = 5'b00100;
`else
  localparam logic [4:0] ExpOvf = 5'b00000;
`endif

  rr_req_collector dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .strobe_i    (strobe),
    .grant_num_i (gnum),
    .grant_val_i (gval),
    .req_o       (req),
    .req_val_o   (req_val),
    .busy_o      (busy),
    .tmo_o       (tmo),
    .gerr_o      (gerr),
    .ovf_o       (ovf),
    .ovf_clr_i   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop(input int kind, input logic [4:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d val %b, required none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == KREQ && e.kind == KREQ) check("snapshot", {27'd0, val}, {27'd0, e.val});
    end
  endtask

  // Monitor: independent of the stimulus thread.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_val) pop(KREQ, req);
        if (tmo)     pop(KTMO, 5'b0);
        if (gerr)    pop(KGERR, 5'b0);
      end
    end
  end

  // Returns at the negedge of the ISSUE cycle.
  task automatic wait_issue();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = req_val;
    end
    check("issue_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called from the ISSUE cycle; grant lands in the first WAIT cycle.
  task automatic grant(input logic [2:0] n);
    @(posedge clk); #1 gnum = n; gval = 1'b1;
    @(posedge clk); #1 gval = 1'b0;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    // Reset with garbage on the inputs; all of it must be discarded.
    rst_n = 1'b0; strobe = 5'b11111; gval = 1'b1; gnum = 3'd0; ovf_clr = 5'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",     {27'd0, req},  32'd0);
    check("rst_req_val", {31'd0, req_val}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_tmo",     {31'd0, tmo},  32'd0);
    check("rst_gerr",    {31'd0, gerr}, 32'd0);
    check("rst_ovf",     {27'd0, ovf},  32'd0);
    rst_n = 1'b1; strobe = 5'b0; gval = 1'b0;
    idle_check(20);

    // Single request with exact latency.
    push(KREQ, 5'b00100);
    @(posedge clk); #1 strobe = 5'b00100;
    @(negedge clk); check("lat_c0_val", {31'd0, req_val}, 32'd0);
    @(posedge clk); #1 strobe = 5'b0;
    @(negedge clk); check("lat_c1_val", {31'd0, req_val}, 32'd0);
    check("lat_c1_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); check("lat_c2_val", {31'd0, req_val}, 32'd1);
    check("lat_c2_req", {27'd0, req}, 32'b00100);
    check("lat_c2_busy", {31'd0, busy}, 32'd1);
    grant(3'd2);
    idle_check(10);

    // Multi-pending: three on source 1, one on source 4.
    push(KREQ, 5'b10010); push(KREQ, 5'b10010); push(KREQ, 5'b10010); push(KREQ, 5'b10000);
    fork
      begin
        @(posedge clk); #1 strobe = 5'b10010;
        @(posedge clk); #1 strobe = 5'b00010;
        @(posedge clk); #1 strobe = 5'b00010;
        @(posedge clk); #1 strobe = 5'b0;
      end
      begin
        wait_issue(); grant(3'd1);
        wait_issue(); grant(3'd1);
        wait_issue(); grant(3'd1);
        wait_issue(); grant(3'd4);
      end
    join
    idle_check(10);

    // Timeout, re-issue, then a grant on the very last WAIT cycle beats expiry.
    push(KREQ, 5'b00001); push(KTMO, 5'b0); push(KREQ, 5'b00001);
    @(posedge clk); #1 strobe = 5'b00001;
    @(posedge clk); #1 strobe = 5'b0;
    wait_issue();
    n = 0; seen = 1'b0;
    while (n < 30 && !seen) begin
      @(negedge clk);
      n++;
      seen = tmo;
    end
    // Eight WAIT cycles, then the registered pulse one cycle later.
    check("tmo_latency", n, TMO + 1);
    wait_issue();
    repeat (TMO) @(posedge clk);
    #1 gnum = 3'd0; gval = 1'b1;
    @(posedge clk); #1 gval = 1'b0;
    idle_check(12);

    // Illegal grants leave the count intact; grant outside WAIT is ignored.
    push(KREQ, 5'b01000); push(KGERR, 5'b0);
    push(KREQ, 5'b01000); push(KGERR, 5'b0);
    push(KREQ, 5'b01000);
    @(posedge clk); #1 strobe = 5'b01000;
    @(posedge clk); #1 strobe = 5'b0;
    wait_issue(); grant(3'd1);
    wait_issue(); grant(3'd7);
    wait_issue(); grant(3'd3);
    idle_check(4);
    @(posedge clk); #1 gnum = 3'd3; gval = 1'b1;
    @(posedge clk); #1 gval = 1'b0;
    idle_check(10);

    // Overflow: six strobes saturate at four; strobe plus grant on a full counter holds it.
    push(KREQ, 5'b00100); push(KTMO, 5'b0);
    repeat (5) push(KREQ, 5'b00100);
    fork
      begin
        @(posedge clk); #1 strobe = 5'b00100;
        repeat (5) begin @(posedge clk); #1 strobe = 5'b00100; end
        @(posedge clk); #1 strobe = 5'b0;
      end
      wait_issue();
    join
    wait_issue();
    @(posedge clk); #1 gnum = 3'd2; gval = 1'b1; strobe = 5'b00100;
    @(posedge clk); #1 gval = 1'b0; strobe = 5'b0;
    repeat (4) begin wait_issue(); grant(3'd2); end
    idle_check(12);
    check("ovf_set", {27'd0, ovf}, {27'd0, ExpOvf});
    @(posedge clk); #1 ovf_clr = 5'b00100;
    @(posedge clk); #1 ovf_clr = 5'b0;
    @(negedge clk); check("ovf_clr", {27'd0, ovf}, 32'd0);

    idle_check(4);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
